ps2_key_decoder: RTL and testbench

- Receives raw PS/2 keyboard clock and data lines and decodes the scan-code frames.
- Holds a level-per-key register for the four game keys in the order {jump, fall, left, right}.
- Sits directly upstream of the player state updater and drives its keys[3:0] input.
- Also exposes each raw decoded byte and a framing-error pulse for debug/LED display.

---
 rtl/ps2_key_decoder.sv | 172 +++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: sync, glitch filter, frame FSM and game-key level decode.
// Define PS2_TIMEOUT_EN to abandon stalled frames after TIMEOUT_CYCLES clk cycles.
module ps2_key_decoder #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [3:0] keys,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int unsigned FcW = $clog2(FILTER_LEN + 1);

   typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

   state_e         state_q, state_d;
   logic [1:0]     clk_s_q, clk_s_d, dat_s_q, dat_s_d;
   logic           filt_q, filt_d, fall_q, fall_d;
   logic [FcW-1:0] fcnt_q, fcnt_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d, code_q, code_d;
   logic           par_q, par_d, ext_q, ext_d, brk_q, brk_d;
   logic [3:0]     keys_q, keys_d;
   logic           code_valid_q, code_valid_d, frame_err_q, frame_err_d;
   logic           din;

`ifdef PS2_TIMEOUT_EN
   localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WdW-1:0] wd_q, wd_d;
`endif

   assign din = dat_s_q[1];

   always_comb begin
      clk_s_d      = {clk_s_q[0], ps2_clk};
      dat_s_d      = {dat_s_q[0], ps2_data};
      filt_d       = filt_q;
      fcnt_d       = '0;
      fall_d       = 1'b0;
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_d        = par_q;
      ext_d        = ext_q;
      brk_d        = brk_q;
      keys_d       = keys_q;
      code_d       = code_q;
      code_valid_d = 1'b0;
      frame_err_d  = 1'b0;

      // Level flips only after FILTER_LEN consecutive disagreeing samples.
      if (clk_s_q[1] != filt_q) begin
         if (fcnt_q == FcW'(FILTER_LEN - 1)) begin
            filt_d = ~filt_q;
            fall_d = filt_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end

      if (fall_q) begin
         unique case (state_q)
            StIdle: begin
               if (!din) begin
                  state_d   = StData;
                  bit_cnt_d = 3'd0;
               end
            end
            StData: begin
               shift_d   = {din, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = StParity;
            end
            StParity: begin
               par_d   = din;
               state_d = StStop;
            end
            StStop: begin
               state_d = StIdle;
               if (din && (^{shift_q, par_q})) begin
                  code_d       = shift_q;
                  code_valid_d = 1'b1;
                  if (shift_q == 8'hE0) begin
                     ext_d = 1'b1;
                  end else if (shift_q == 8'hF0) begin
                     brk_d = 1'b1;
                  end else begin
                     if (!ext_q && shift_q == 8'h12) keys_d[3] = ~brk_q;
                     if (ext_q && shift_q == 8'h72) keys_d[2] = ~brk_q;
                     if (ext_q && shift_q == 8'h6B) keys_d[1] = ~brk_q;
                     if (ext_q && shift_q == 8'h74) keys_d[0] = ~brk_q;
                     ext_d = 1'b0;
                     brk_d = 1'b0;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end

`ifdef PS2_TIMEOUT_EN
      wd_d = '0;
      if (state_q != StIdle && !fall_q) begin
         if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
            state_d     = StIdle;
            bit_cnt_d   = 3'd0;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
         end else begin
            wd_d = wd_q + 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s_q      <= 2'b11;
         dat_s_q      <= 2'b11;
         filt_q       <= 1'b1;
         fcnt_q       <= '0;
         fall_q       <= 1'b0;
         state_q      <= StIdle;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         par_q        <= 1'b0;
         ext_q        <= 1'b0;
         brk_q        <= 1'b0;
         keys_q       <= 4'b0000;
         code_q       <= 8'h00;
         code_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         clk_s_q      <= clk_s_d;
         dat_s_q      <= dat_s_d;
         filt_q       <= filt_d;
         fcnt_q       <= fcnt_d;
         fall_q       <= fall_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         ext_q        <= ext_d;
         brk_q        <= brk_d;
         keys_q       <= keys_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

`ifdef PS2_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end
`endif

   assign keys       = keys_q;
   assign code       = code_q;
   assign code_valid = code_valid_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed plus randomized bench for ps2_key_decoder against a byte-level key model.
// Timeout step runs only when PS2_TIMEOUT_EN is defined.
module tb_ps2_key_decoder;

   localparam int unsigned FilterLen = 8;
   localparam int unsigned TimeoutCycles = 1000;
   localparam int HalfPer = 20;

   logic       clk = 1'b0;
   logic       rst, ps2_clk, ps2_data;
   logic [3:0] keys;
   logic [7:0] code;
   logic       code_valid, frame_err;

   ps2_key_decoder #(
      .FILTER_LEN    (FilterLen),
      .TIMEOUT_CYCLES(TimeoutCycles)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .keys      (keys),
      .code      (code),
      .code_valid(code_valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Pulse monitor
   int   cv_cnt = 0, fe_cnt = 0, cv_long = 0, fe_long = 0;
   logic cv_prev = 1'b0, fe_prev = 1'b0;
   always @(negedge clk) begin
      if (code_valid) cv_cnt <= cv_cnt + 1;
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (code_valid && cv_prev) cv_long <= cv_long + 1;
      if (frame_err && fe_prev) fe_long <= fe_long + 1;
      cv_prev <= code_valid;
      fe_prev <= frame_err;
   end

   // Reference model: byte-level key state
   logic [3:0] m_keys = 4'b0;
   logic [7:0] m_code = 8'h00;
   logic       m_ext = 1'b0, m_brk = 1'b0;

   task automatic model_byte(input logic [7:0] b);
      m_code = b;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         case ({m_ext, b})
            {1'b0, 8'h12}: m_keys[3] = !m_brk;
            {1'b1, 8'h72}: m_keys[2] = !m_brk;
            {1'b1, 8'h6B}: m_keys[1] = !m_brk;
            {1'b1, 8'h74}: m_keys[0] = !m_brk;
            default: ;
         endcase
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Send the first nbits of an 11-bit frame; glitch adds short low pulses in high phases.
   task automatic send_bits(input logic [7:0] b, input logic bad_par, input logic glitch,
                            input int nbits);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         if (glitch) begin
            cycles(6);
            ps2_clk = 1'b0;
            cycles(FilterLen - 2);
            ps2_clk = 1'b1;
            cycles(8);
         end else begin
            cycles(HalfPer);
         end
         ps2_clk = 1'b0;
         cycles(HalfPer);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      cycles(HalfPer + 10);
   endtask

   task automatic frame(input logic [7:0] b, input logic bad_par, input logic glitch);
      int cv0, fe0;
      cv0 = cv_cnt;
      fe0 = fe_cnt;
      send_bits(b, bad_par, glitch, 11);
      if (!bad_par) model_byte(b);
      check("code", {24'b0, code}, {24'b0, m_code});
      check("keys", {28'b0, keys}, {28'b0, m_keys});
      check("code_valid_pulses", cv_cnt - cv0, bad_par ? 0 : 1);
      check("frame_err_pulses", fe_cnt - fe0, bad_par ? 1 : 0);
   endtask

   initial begin
      logic [7:0] pool [7];
      logic [7:0] b;
      int         cv0;
      pool = '{8'hE0, 8'hF0, 8'h12, 8'h72, 8'h6B, 8'h74, 8'h00};
      rst = 1'b1;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      cycles(5);
      rst = 1'b0;
      cycles(2);
      check("reset_keys", {28'b0, keys}, 32'h0);
      check("reset_code", {24'b0, code}, 32'h0);
      check("reset_cv", {31'b0, code_valid}, 32'h0);
      check("reset_fe", {31'b0, frame_err}, 32'h0);

      frame(8'h12, 1'b0, 1'b0);
      check("jump_held", {28'b0, keys}, 32'h8);
      frame(8'hF0, 1'b0, 1'b0);
      frame(8'h12, 1'b0, 1'b0);

      frame(8'hE0, 1'b0, 1'b0);
      frame(8'h6B, 1'b0, 1'b0);
      frame(8'hE0, 1'b0, 1'b0);
      frame(8'h74, 1'b0, 1'b0);
      check("left_right", {28'b0, keys}, 32'h3);
      cv0 = cv_cnt;
      frame(8'hE0, 1'b0, 1'b0);
      frame(8'hF0, 1'b0, 1'b0);
      frame(8'h6B, 1'b0, 1'b0);
      check("break_pulses", cv_cnt - cv0, 3);
      check("left_released", {28'b0, keys}, 32'h1);
      frame(8'hE0, 1'b0, 1'b0);
      frame(8'hF0, 1'b0, 1'b0);
      frame(8'h74, 1'b0, 1'b0);

      frame(8'hE0, 1'b0, 1'b0);
      frame(8'h12, 1'b0, 1'b0);
      check("fake_shift", {28'b0, keys}, 32'h0);
      frame(8'h12, 1'b0, 1'b0);
      check("jump_after_fake", {28'b0, keys}, 32'h8);

      frame(8'h72, 1'b1, 1'b0);
      frame(8'hE0, 1'b0, 1'b0);
      frame(8'h72, 1'b0, 1'b0);
      check("fall_held", {31'b0, keys[2]}, 32'h1);

      frame(8'h1C, 1'b0, 1'b1);

      send_bits(8'h6B, 1'b0, 1'b0, 5);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      check("midrst_keys", {28'b0, keys}, 32'h0);
      check("midrst_code", {24'b0, code}, 32'h0);
      check("midrst_cv", {31'b0, code_valid}, 32'h0);
      check("midrst_fe", {31'b0, frame_err}, 32'h0);
      m_keys = 4'b0;
      m_code = 8'h00;
      m_ext = 1'b0;
      m_brk = 1'b0;
      cycles(5);
      frame(8'h12, 1'b0, 1'b0);

`ifdef PS2_TIMEOUT_EN
      frame(8'hF0, 1'b0, 1'b0);
      frame(8'hE0, 1'b0, 1'b0);
      cv0 = fe_cnt;
      send_bits(8'h55, 1'b0, 1'b0, 4);
      cycles(TimeoutCycles + 50);
      check("timeout_fe", fe_cnt - cv0, 1);
      check("timeout_keys", {28'b0, keys}, {28'b0, m_keys});
      m_ext = 1'b0;
      m_brk = 1'b0;
      frame(8'h12, 1'b0, 1'b0);
      check("jump_after_timeout", {31'b0, keys[3]}, 32'h1);
`endif

      for (int i = 0; i < 40; i++) begin
         b = pool[$urandom_range(0, 6)];
         if (b == 8'h00) b = 8'($urandom_range(0, 255));
         frame(b, ($urandom_range(0, 7) == 0), 1'b0);
      end

      check("cv_single_cycle", cv_long, 0);
      check("fe_single_cycle", fe_long, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
